// File: rtl/pulse_monitor.sv
// Tick-interval monitor: measures cycles between rising edges of pulse_in, grades them
// against EXPECTED +/- TOL, and flags loss after TIMEOUT. Optional running average under PULSE_MONITOR_AVG_EN.
module pulse_monitor #(
   parameter int EXPECTED = 1_000_000,
   parameter int TOL      = 1_000,
   parameter int TIMEOUT  = 2_000_000,
   parameter int WIDTH    = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             pulse_in,
   input  logic             clear,
   output logic [WIDTH-1:0] period,
   output logic             period_valid,
   output logic             in_range,
   output logic             early,
   output logic             lost,
   output logic [15:0]      pulse_count
`ifdef PULSE_MONITOR_AVG_EN
   ,
   output logic [WIDTH-1:0] avg_period
`endif
);

   // Lower bound clamps to zero when the tolerance exceeds the nominal period.
   localparam int              LO_INT = (TOL > EXPECTED) ? 0 : EXPECTED - TOL;
   localparam logic [WIDTH-1:0] LO_B   = WIDTH'(LO_INT);
   localparam logic [WIDTH-1:0] HI_B   = WIDTH'(EXPECTED + TOL);
   localparam logic [WIDTH-1:0] TMO    = WIDTH'(TIMEOUT);
   localparam logic [WIDTH-1:0] TMO_M1 = WIDTH'(TIMEOUT - 1);
   localparam logic [WIDTH-1:0] ONE    = WIDTH'(1);

   typedef enum logic [1:0] {IDLE, TRACK, LOST} state_t;

   state_t           state, state_nxt;
   logic             pulse_q;
   logic             edge_det;
   logic [WIDTH-1:0] cnt, cnt_nxt;
   logic [WIDTH-1:0] period_nxt;
   logic             pv_nxt, ir_nxt, early_nxt, lost_nxt;
   logic [15:0]      pc_nxt;
`ifdef PULSE_MONITOR_AVG_EN
   logic [WIDTH-1:0] avg_nxt;
   logic             avg_init, avg_init_nxt;
`endif

   function automatic logic [WIDTH-1:0] sat_inc(input logic [WIDTH-1:0] v);
      return (v >= TMO) ? TMO : v + ONE;
   endfunction

`ifdef PULSE_MONITOR_AVG_EN
   function automatic logic [WIDTH-1:0] avg_update(input logic [WIDTH-1:0] avg,
                                                    input logic [WIDTH-1:0] sample);
      return avg - (avg >> 3) + (sample >> 3);
   endfunction
`endif

   assign edge_det = pulse_in & ~pulse_q;

   always_comb begin
      state_nxt  = state;
      cnt_nxt    = edge_det ? ONE : sat_inc(cnt);
      period_nxt = period;
      pv_nxt     = 1'b0;
      ir_nxt     = in_range;
      early_nxt  = early;
      lost_nxt   = lost;
      pc_nxt     = pulse_count;
`ifdef PULSE_MONITOR_AVG_EN
      avg_nxt      = avg_period;
      avg_init_nxt = avg_init;
`endif
      if (clear) begin
         state_nxt  = IDLE;
         cnt_nxt    = '0;
         period_nxt = '0;
         ir_nxt     = 1'b0;
         early_nxt  = 1'b0;
         lost_nxt   = 1'b0;
         pc_nxt     = '0;
`ifdef PULSE_MONITOR_AVG_EN
         avg_nxt      = '0;
         avg_init_nxt = 1'b0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (edge_det) state_nxt = TRACK;
            end
            TRACK: begin
               if (edge_det) begin
                  period_nxt = cnt;
                  pv_nxt     = 1'b1;
                  pc_nxt     = pulse_count + 16'd1;
                  ir_nxt     = (cnt >= LO_B) && (cnt <= HI_B);
                  early_nxt  = (cnt < LO_B);
`ifdef PULSE_MONITOR_AVG_EN
                  avg_nxt      = avg_init ? avg_update(avg_period, cnt) : cnt;
                  avg_init_nxt = 1'b1;
`endif
               end else if (cnt == TMO_M1) begin
                  lost_nxt  = 1'b1;
                  ir_nxt    = 1'b0;
                  state_nxt = LOST;
               end
            end
            LOST: begin
               // The interval spanning the loss is discarded; only re-arm.
               if (edge_det) begin
                  lost_nxt  = 1'b0;
                  state_nxt = TRACK;
               end
            end
            default: state_nxt = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= IDLE;
         pulse_q      <= 1'b0;
         cnt          <= '0;
         period       <= '0;
         period_valid <= 1'b0;
         in_range     <= 1'b0;
         early        <= 1'b0;
         lost         <= 1'b0;
         pulse_count  <= '0;
`ifdef PULSE_MONITOR_AVG_EN
         avg_period   <= '0;
         avg_init     <= 1'b0;
`endif
      end else begin
         state        <= state_nxt;
         pulse_q      <= pulse_in;
         cnt          <= cnt_nxt;
         period       <= period_nxt;
         period_valid <= pv_nxt;
         in_range     <= ir_nxt;
         early        <= early_nxt;
         lost         <= lost_nxt;
         pulse_count  <= pc_nxt;
`ifdef PULSE_MONITOR_AVG_EN
         avg_period   <= avg_nxt;
         avg_init     <= avg_init_nxt;
`endif
      end
   end

endmodule

// File: doc/pulse_monitor.md
Name: pulse_monitor

Overview:
- Consumer end of the periodic tick generator: watches a single-cycle tick stream and measures the clk-cycle interval between ticks.
- Checks each interval against a nominal period and tolerance, and flags missing ticks as lost.
- Sits downstream of the tick source on the iRobot figure-8 board, as a health and rate check for motion timing.

Parameters:
- EXPECTED, 1_000_000, nominal clk cycles between consecutive tick rising edges.
- TOL, 1_000, allowed deviation (cycles) either side of EXPECTED.
- TIMEOUT, 2_000_000, cycles since the last edge at which the tick is declared lost; must be greater than EXPECTED+TOL.
- WIDTH, 32, width of the interval counter and the period output.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- pulse_in  in  1  tick input, synchronous to clk.
- clear  in  1  synchronous restart to IDLE.
- period  out  WIDTH  last measured interval in cycles.
- period_valid  out  1  one-cycle strobe when period updates.
- in_range  out  1  last period within EXPECTED±TOL.
- early  out  1  last period < EXPECTED-TOL.
- lost  out  1  no edge for TIMEOUT cycles.
- pulse_count  out  16  number of measured periods, wraps modulo 2^16.

Behaviour:
- Reset and clock: one clock, clk; rst is asynchronous and active-high.
- Reset values: all outputs 0; cnt=0; pulse_q=0; state=IDLE.
- Edge detect: edge = pulse_in & ~pulse_q; pulse_q <= pulse_in every cycle.
  - A level held high counts as one edge.
  - Back-to-back single-cycle highs count as separate edges only if separated by a low cycle.
- Counter:
  - On edge: cnt <= 1.
  - Otherwise: cnt <= cnt+1, saturating at TIMEOUT.
  - Result: at an edge, cnt equals the exact cycle distance from the previous edge.
- All outputs are registered and appear the cycle after the edge cycle.
- States:
  - IDLE: waiting for the first edge. On edge -> TRACK; no period produced.
  - TRACK, on edge:
    - period <= cnt, period_valid <= 1 for one cycle, pulse_count <= pulse_count+1.
    - in_range <= (cnt >= EXPECTED-TOL) && (cnt <= EXPECTED+TOL).
    - early <= (cnt < EXPECTED-TOL).
    - Stay in TRACK.
  - TRACK, no edge and cnt == TIMEOUT-1: lost <= 1, in_range <= 0, move to LOST. lost rises exactly TIMEOUT cycles after the last edge cycle.
  - LOST, on edge: lost <= 0, cnt <= 1, move to TRACK. No period_valid, because the interval spans the loss and is discarded. period, early and pulse_count hold.
- period, in_range and early hold their values between edges.
- period_valid is 0 in every cycle not following a TRACK edge.
- Subtraction EXPECTED-TOL: evaluate at elaboration; if TOL > EXPECTED, treat the lower bound as 0.
- clear: synchronous and takes priority over a simultaneous edge.
  - Next cycle: state=IDLE, cnt=0, all outputs 0.
  - The edge in the clear cycle is ignored, but pulse_q still updates.
- Reset mid-operation: outputs drop to 0 immediately, without waiting for a clock edge. After release, the first edge only re-arms (IDLE->TRACK).
- Counter saturation: cnt never wraps; it holds at TIMEOUT while LOST.

Optional Feature:
- Macro PULSE_MONITOR_AVG_EN.
- When defined:
  - Adds output avg_period [WIDTH-1:0], reset 0.
  - On each period_valid update: avg_period <= avg_period - (avg_period>>3) + (cnt>>3).
  - The first measurement after reset or clear loads cnt directly.
  - clear zeroes avg_period.
- When undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan (EXPECTED=10, TOL=1, TIMEOUT=25):
1. Reset, then single-cycle ticks every 10 cycles -> first edge gives no strobe; second edge gives period=10, period_valid high one cycle, in_range=1, early=0, pulse_count=1; pulse_count=3 after the fourth edge.
2. In TRACK, next tick 7 cycles later -> period=7, early=1, in_range=0; following tick 11 cycles later -> period=11, in_range=1, early=0.
3. No tick for 25 cycles after an edge -> lost=1 on the cycle 25 after the edge; next tick -> lost=0, no period_valid; tick 10 cycles later -> period=10 strobed.
4. clear asserted in the same cycle as a TRACK edge -> no period_valid; next cycle all outputs 0, state IDLE; next two ticks 10 apart -> period=10, pulse_count=1.
5. rst pulsed asynchronously between clk edges while in TRACK with pulse_count=5 -> outputs 0 before the next clk edge; resume behaves as scenario 1.
6. pulse_in held high for 5 cycles, then low, then a tick 10 cycles after the first rising edge -> exactly one measurement, period=10.
7. With PULSE_MONITOR_AVG_EN and periods 10 then 18 -> avg_period=10, then 10-1+2=11.
